// File: rtl/alu_pkg.sv
// Shared opcode encodings and the multiply/divide sequencer states for the execute-stage ALU.
// Opcodes are 4-bit; wider select buses zero-extend them before comparing.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_MFHI  = 4'b1011;
  localparam logic [3:0] OP_MFLO  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned multiply (shift-add) / restoring divide into HI/LO; W+1 cycles start to done.
// Starts are only taken in IDLE or DONE; the caller stalls on busy, starts during BUSY are dropped.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int CW = $clog2(DATA_WIDTH);

  state_t                state;
  logic [CW-1:0]         count;
  logic                  op_div;
  // Multiplicand for MULTU, divisor for DIVU.
  logic [DATA_WIDTH-1:0] m;
  logic [DATA_WIDTH-1:0] acc_hi;
  logic [DATA_WIDTH-1:0] acc_lo;

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   div_shift;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] step_hi;
  logic [DATA_WIDTH-1:0] step_lo;

  // One radix-2 step. A zero divisor always "fits", so the quotient fills with ones
  // and the remainder ends up holding the dividend without special casing.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : {(DATA_WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
    div_ge    = div_shift >= {1'b0, m};
    if (op_div) begin
      step_hi = div_ge ? (div_shift[DATA_WIDTH-1:0] - m) : div_shift[DATA_WIDTH-1:0];
      step_lo = {acc_lo[DATA_WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      op_div      <= 1'b0;
      m           <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_div <= is_div;
            m      <= is_div ? operand2 : operand1;
            acc_hi <= '0;
            acc_lo <= is_div ? operand1 : operand2;
            count  <= CW'(DATA_WIDTH - 1);
            busy   <= 1'b1;
            state  <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (count == '0) begin
            hi    <= step_hi;
            lo    <= step_lo;
            if (op_div) div_by_zero <= (m == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU: combinational logic/arithmetic ops plus HI/LO moves; MULTU/DIVU take W+1 cycles.
// The control FSM stalls on busy and samples the one-cycle done pulse; no other backpressure.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [OP_WIDTH-1:0]   ALUoperations,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] resultOut,
  output logic                  carryOut,
  output logic                  overflow,
  output logic                  isZero,
  output logic                  busy,
  output logic                  done,
  output logic                  divByZero,
  output logic [DATA_WIDTH-1:0] hiOut,
  output logic [DATA_WIDTH-1:0] loOut
);

  logic                  is_mul;
  logic                  is_div;
  logic [DATA_WIDTH:0]   add_sum;
  logic [DATA_WIDTH:0]   sub_sum;
  logic                  add_ovf;
  logic                  sub_ovf;
  logic                  slt;
  logic                  sltu;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  assign is_mul = (ALUoperations == OP_WIDTH'(OP_MULTU));
  assign is_div = (ALUoperations == OP_WIDTH'(OP_DIVU));

  muldiv_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .start       (start && (is_mul || is_div)),
    .is_div      (is_div),
    .operand1    (operand1),
    .operand2    (operand2),
    .busy        (busy),
    .done        (done),
    .div_by_zero (divByZero),
    .hi          (hi),
    .lo          (lo)
  );

  assign hiOut = hi;
  assign loOut = lo;

  assign add_sum = {1'b0, operand1} + {1'b0, operand2};
  assign sub_sum = {1'b0, operand1} + {1'b0, ~operand2} + (DATA_WIDTH+1)'(1);
  // Signed overflow: result sign disagrees with operands that (effectively) share a sign.
  assign add_ovf = (operand1[DATA_WIDTH-1] == operand2[DATA_WIDTH-1]) &&
                   (add_sum[DATA_WIDTH-1] != operand1[DATA_WIDTH-1]);
  assign sub_ovf = (operand1[DATA_WIDTH-1] != operand2[DATA_WIDTH-1]) &&
                   (sub_sum[DATA_WIDTH-1] != operand1[DATA_WIDTH-1]);
  assign slt     = $signed(operand1) < $signed(operand2);
  assign sltu    = operand1 < operand2;

  always_comb begin
    resultOut = '0;
    carryOut  = 1'b0;
    overflow  = 1'b0;
    case (ALUoperations)
      OP_WIDTH'(OP_AND):  resultOut = operand1 & operand2;
      OP_WIDTH'(OP_OR):   resultOut = operand1 | operand2;
      OP_WIDTH'(OP_XOR):  resultOut = operand1 ^ operand2;
      OP_WIDTH'(OP_NOR):  resultOut = ~(operand1 | operand2);
      OP_WIDTH'(OP_ADD): begin
        resultOut = add_sum[DATA_WIDTH-1:0];
        carryOut  = add_sum[DATA_WIDTH];
        overflow  = add_ovf;
      end
      OP_WIDTH'(OP_SUB): begin
        resultOut = sub_sum[DATA_WIDTH-1:0];
        carryOut  = sub_sum[DATA_WIDTH];
        overflow  = sub_ovf;
      end
      OP_WIDTH'(OP_SLT):  resultOut = {{(DATA_WIDTH-1){1'b0}}, slt};
      OP_WIDTH'(OP_SLTU): resultOut = {{(DATA_WIDTH-1){1'b0}}, sltu};
      OP_WIDTH'(OP_MFHI): resultOut = hi;
      OP_WIDTH'(OP_MFLO): resultOut = lo;
      default:            resultOut = '0;
    endcase
  end

  assign isZero = (resultOut == '0);

endmodule

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Parametrised next-generation ALU for the multi-cycle datapath. It keeps the single-cycle logic and arithmetic operations (AND, OR, ADD, SUB, SLT) and adds XOR, NOR, unsigned compare, and HI/LO transfer. It also adds an iterative unsigned multiplier/divider that writes a HI/LO register pair under a start/busy/done handshake. It sits in the execute stage; the control FSM stalls on `busy` and samples `done`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width; must be ≥ 4 and even.
- `OP_WIDTH`, 4, width of operation select.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `operand1` in DATA_WIDTH: first operand, dividend, multiplicand.
- `operand2` in DATA_WIDTH: second operand, divisor, multiplier.
- `ALUoperations` in OP_WIDTH: operation select.
- `start` in 1: launch MULTU/DIVU; ignored for all other ops.
- `resultOut` out DATA_WIDTH: combinational result.
- `carryOut` out 1: carry of ADD/SUB.
- `overflow` out 1: signed overflow of ADD/SUB.
- `isZero` out 1: resultOut == 0.
- `busy` out 1: iteration in progress.
- `done` out 1: one-cycle completion pulse.
- `divByZero` out 1: registered flag of the last completed DIVU.
- `hiOut`, `loOut` out DATA_WIDTH: HI/LO register contents.

## Operation
Combinational ops (resultOut valid in the same cycle, independent of FSM state):
- 0000 AND; 0001 OR; 0011 XOR; 0100 NOR.
- 0010 ADD: `{carryOut,resultOut} = op1 + op2`.
- 0110 SUB: `op1 + ~op2 + 1`; carryOut = carry out (1 = no borrow).
- 0111 SLT: signed compare; result 1 or 0.
- 1000 SLTU: unsigned compare; result 1 or 0.
- 1011 MFHI: result = HI. 1100 MFLO: result = LO.
- 1001 MULTU and 1010 DIVU: resultOut = 0.
- Any other code: result 0, carryOut 0, overflow 0.
- overflow is 1 only for ADD/SUB when the signed sum's sign mismatches the operands' signs; otherwise 0. carryOut is 0 for all non-ADD/SUB ops.

Sequential FSM, states IDLE, BUSY, DONE:
- IDLE/DONE with `start`=1 and op MULTU or DIVU: latch operands and op, count ← DATA_WIDTH−1, go to BUSY.
- Any other `start`: no state change.
- BUSY: one iteration per cycle.
  - MULTU: shift-add radix-2 into a 2W-bit accumulator.
  - DIVU: restoring divide, remainder/quotient shift.
  - `start` is ignored while BUSY.
- BUSY with count == 0: perform the final iteration, write HI/LO on that edge, go to DONE.
- DONE: lasts one cycle, then goes to IDLE unless a new start is accepted.
- MULTU result: HI = product[2W−1:W], LO = product[W−1:0].
- DIVU result: LO = quotient, HI = remainder.
- DIVU with divisor 0: full latency is still taken; LO = all ones, HI = dividend; divByZero ← 1.
- Any completed DIVU with a nonzero divisor clears divByZero. MULTU leaves it unchanged.
- Operand inputs may change while BUSY; only the latched copies are used.

## Timing
- Reset state: state IDLE; HI, LO, count, divByZero all 0.
- Outputs under reset: busy 0, done 0, hiOut and loOut 0. resultOut, carryOut, overflow, isZero follow the inputs combinationally.
- Start is accepted at edge E0.
- busy is 1 in the cycles after edges E0 … E(W−1), i.e. W cycles.
- HI/LO are updated at edge EW. done = 1 for exactly the cycle after EW; busy = 0 in that cycle.
- Latency from start acceptance to done is W+1 cycles; W = 32 gives 33.
- Back-to-back: a start in the DONE cycle is accepted; busy rises the next cycle with no idle gap.
- MFHI/MFLO in the DONE cycle return the new values.
- Asserting reset mid-BUSY aborts immediately: IDLE, HI/LO cleared, no done pulse.

## Structure
- Package `alu_pkg`: opcode localparams (AND … MFLO) and the FSM state encoding (IDLE, BUSY, DONE).
- Sub-module `muldiv_core`: FSM, counter, latched operands, accumulator, HI/LO, divByZero.
- Top level: combinational op mux plus flag logic, instantiating `muldiv_core`.

## Test plan
- Combinational sweep:
  - ADD 0x7FFFFFFF + 1 → 0x80000000, overflow 1, carry 0.
  - ADD 0xFFFFFFFF + 1 → 0, carry 1, isZero 1.
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU with the same operands → 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start pulse → busy for 32 cycles, done at cycle 33, HI 0xFFFFFFFE, LO 0x00000001.
- DIVU 100 / 7 → LO 14, HI 2, divByZero 0. Then DIVU 5 / 0 → LO 0xFFFFFFFF, HI 5, divByZero 1.
- Start asserted mid-BUSY with different operands → ignored; the original result completes at the original cycle.
- Start asserted in the DONE cycle → the second operation completes exactly 33 cycles after the first done.
- Reset asserted at iteration 10 of a MULTU → busy 0 immediately, HI/LO 0, no done. MULTU 3 × 4 afterwards → LO 12.
